// File: rtl/div_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : div_sequencer_pkg
// Brief  : Shared types for the M-extension divide unit (ops, FU occupancy,
//          sequencer states, data bus width).
// Rev    : 1.0  initial release
// ============================================================================
package div_sequencer_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] data_bus_t;

    typedef enum logic [1:0] {
        DIV_  = 2'd0,
        DIVU_ = 2'd1,
        REM_  = 2'd2,
        REMU_ = 2'd3
    } div_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2
    } div_state_e;

    function automatic logic is_signed_op(input div_ops_e op);
        return (op == DIV_) || (op == REM_);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : div_sequencer_if
// Brief  : Request/response bundle between issue logic and the divide unit.
// Rev    : 1.0  initial release
// ============================================================================
interface div_sequencer_if
    import div_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN
);
    logic [DATA_WIDTH-1:0] dividend_i;
    logic [DATA_WIDTH-1:0] divisor_i;
    div_ops_e              operation_i;
    logic                  data_valid_i;
    logic                  clear_i;
    logic [DATA_WIDTH-1:0] result_o;
    logic                  data_valid_o;
    logic                  divide_by_zero_o;
    fu_state_e             fu_state_o;

    modport master (
        output dividend_i, divisor_i, operation_i, data_valid_i, clear_i,
        input  result_o, data_valid_o, divide_by_zero_o, fu_state_o
    );

    modport slave (
        input  dividend_i, divisor_i, operation_i, data_valid_i, clear_i,
        output result_o, data_valid_o, divide_by_zero_o, fu_state_o
    );
endinterface
`default_nettype wire

// File: rtl/div_restoring_step.sv
`default_nettype none
// ============================================================================
// Module : div_restoring_step
// Brief  : One combinational restoring shift-subtract step.
// Rev    : 1.0  initial release
// ============================================================================
module div_restoring_step
    import div_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN
) (
    input  wire logic [DATA_WIDTH-1:0] i_remainder,
    input  wire logic [DATA_WIDTH-1:0] i_quotient,
    input  wire logic [DATA_WIDTH-1:0] i_divisor,
    output logic      [DATA_WIDTH-1:0] o_remainder,
    output logic      [DATA_WIDTH-1:0] o_quotient
);
    logic [DATA_WIDTH:0]   w_rem_sh;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_diff;

    // Shifted remainder needs one extra bit; the difference always fits in
    // DATA_WIDTH bits whenever it is kept.
    assign w_rem_sh    = {i_remainder, i_quotient[DATA_WIDTH-1]};
    assign w_ge        = (w_rem_sh >= {1'b0, i_divisor});
    assign w_diff      = w_rem_sh[DATA_WIDTH-1:0] - i_divisor;
    assign o_remainder = w_ge ? w_diff : w_rem_sh[DATA_WIDTH-1:0];
    assign o_quotient  = {i_quotient[DATA_WIDTH-2:0], w_ge};
endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module : div_sequencer
// Brief  : Iterative DIV/DIVU/REM/REMU controller (restoring, one bit/cycle).
//          Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed
//          overflow bypass the iteration phase.
// Rev    : 1.0  initial release
// ============================================================================
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN
) (
    input wire logic       clk_i,
    input wire logic       rst_i,
    div_sequencer_if.slave bus
);
    localparam int                c_cnt_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] c_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_e            r_state, w_state_next;
    div_ops_e              r_op;
    logic [DATA_WIDTH-1:0] r_rem, r_quo, r_divisor, r_dividend_raw, r_result;
    logic                  r_q_sign, r_r_sign, r_div_zero, r_overflow;
    logic                  r_valid, r_dbz;
    logic [c_cnt_w-1:0]    r_cnt;

    logic                  w_accept, w_signed_in, w_a_neg, w_b_neg;
    logic                  w_div_zero_in, w_ovf_in;
    logic [DATA_WIDTH-1:0] w_a_abs, w_b_abs, w_rem_next, w_quo_next;
    logic                  w_is_rem, w_neg;
    logic [DATA_WIDTH-1:0] w_mag, w_fixed;

    assign w_accept      = (r_state == IDLE) && bus.data_valid_i && !bus.clear_i;
    assign w_signed_in   = is_signed_op(bus.operation_i);
    assign w_a_neg       = w_signed_in && bus.dividend_i[DATA_WIDTH-1];
    assign w_b_neg       = w_signed_in && bus.divisor_i[DATA_WIDTH-1];
    assign w_a_abs       = w_a_neg ? -bus.dividend_i : bus.dividend_i;
    assign w_b_abs       = w_b_neg ? -bus.divisor_i  : bus.divisor_i;
    assign w_div_zero_in = (bus.divisor_i == '0);
    assign w_ovf_in      = w_signed_in && (bus.dividend_i == c_min) && (bus.divisor_i == '1);

    div_restoring_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .i_remainder (r_rem),
        .i_quotient  (r_quo),
        .i_divisor   (r_divisor),
        .o_remainder (w_rem_next),
        .o_quotient  (w_quo_next)
    );

    // Result selection, sign correction and RISC-V special-case overrides.
    always_comb begin
        w_is_rem = (r_op == REM_) || (r_op == REMU_);
        w_mag    = w_is_rem ? r_rem : r_quo;
        w_neg    = is_signed_op(r_op) && (w_is_rem ? r_r_sign : r_q_sign);
        w_fixed  = w_neg ? -w_mag : w_mag;
        if (r_div_zero) begin
            w_fixed = w_is_rem ? r_dividend_raw : '1;
        end else if (r_overflow) begin
            w_fixed = w_is_rem ? '0 : c_min;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef DIV_FAST_SPECIAL_EN
                    w_state_next = (w_div_zero_in || w_ovf_in) ? FIX : DIVIDE;
`else
                    w_state_next = DIVIDE;
`endif
                end
            end
            DIVIDE:  if (r_cnt == c_last) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (bus.clear_i) w_state_next = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op           <= DIV_;
            r_rem          <= '0;
            r_quo          <= '0;
            r_divisor      <= '0;
            r_dividend_raw <= '0;
            r_result       <= '0;
            r_q_sign       <= 1'b0;
            r_r_sign       <= 1'b0;
            r_div_zero     <= 1'b0;
            r_overflow     <= 1'b0;
            r_valid        <= 1'b0;
            r_dbz          <= 1'b0;
            r_cnt          <= '0;
        end else begin
            r_valid <= 1'b0;
            r_dbz   <= 1'b0;
            if (!bus.clear_i) begin
                case (r_state)
                    IDLE: begin
                        if (bus.data_valid_i) begin
                            r_op           <= bus.operation_i;
                            r_quo          <= w_a_abs;
                            r_divisor      <= w_b_abs;
                            r_dividend_raw <= bus.dividend_i;
                            r_rem          <= '0;
                            r_cnt          <= '0;
                            r_q_sign       <= w_a_neg ^ w_b_neg;
                            r_r_sign       <= w_a_neg;
                            r_div_zero     <= w_div_zero_in;
                            r_overflow     <= w_ovf_in;
                        end
                    end
                    DIVIDE: begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
                    end
                    FIX: begin
                        r_result <= w_fixed;
                        r_valid  <= 1'b1;
                        r_dbz    <= r_div_zero;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.result_o         = r_result;
    assign bus.data_valid_o     = r_valid;
    assign bus.divide_by_zero_o = r_dbz;
    assign bus.fu_state_o       = (r_state == IDLE) ? FREE : BUSY;
endmodule
`default_nettype wire
